// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Optional input digit check: BCD2BIN_CHECK_EN.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int DIGITS_DEF = 3;
  localparam int BW_DEF     = 10;

  localparam logic [3:0] BCD_CORR = 4'd3;

  // True when BW bits can hold the largest DIGITS-digit decimal value.
  function automatic bit bw_ok(input int digits, input int bw);
    longint unsigned lim;
    lim = 64'd1;
    for (int i = 0; i < digits; i++) begin
      lim = lim * 64'd10;
    end
    return (bw > 0) && (bw < 64) &&
           ((64'd1 << bw) > (lim - 64'd1));
  endfunction

endpackage

// File: rtl/bcd2bin_seq_corr.sv
// One BCD digit of the reverse double-dabble correction.
// Undoes the +3 adjust of the forward converter.
module bcd_digit_corr
  import bcd2bin_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd8) ? d - BCD_CORR : d;

endmodule

// File: rtl/bcd2bin_seq.sv
// Iterative BCD-to-binary converter, one shift/correct per clock.
// Define BCD2BIN_CHECK_EN to flag non-BCD digits via out_err.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BW     = BW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW-1:0]         out_bin,
  output logic                  out_err
);

  localparam int NB = 4 * DIGITS;
  localparam int CW = $clog2(BW + 1);

  if (!bw_ok(DIGITS, BW)) begin : g_bw_bad
    $error("bcd2bin_seq: BW too narrow for DIGITS");
  end

  state_t          state_q, state_d;
  logic [NB-1:0]   bcd_sr_q, bcd_sr_d;
  logic [BW-1:0]   bin_sr_q, bin_sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   out_bin_q, out_bin_d;

  logic [NB-1:0]   bcd_shr;
  logic [NB-1:0]   bcd_corr;
  logic [BW-1:0]   bin_shr;

  assign bcd_shr = {1'b0, bcd_sr_q[NB-1:1]};
  assign bin_shr = {bcd_sr_q[0], bin_sr_q[BW-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .d (bcd_shr[4*g +: 4]),
      .q (bcd_corr[4*g +: 4])
    );
  end

`ifdef BCD2BIN_CHECK_EN
  logic err_q, err_d;
  logic has_bad;

  always_comb begin
    has_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_bcd[4*i +: 4] > 4'd9) begin
        has_bad = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_sr_q  <= '0;
      bin_sr_q  <= '0;
      cnt_q     <= '0;
      out_bin_q <= '0;
`ifdef BCD2BIN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bcd_sr_q  <= bcd_sr_d;
      bin_sr_q  <= bin_sr_d;
      cnt_q     <= cnt_d;
      out_bin_q <= out_bin_d;
`ifdef BCD2BIN_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_sr_d  = bcd_sr_q;
    bin_sr_d  = bin_sr_q;
    cnt_d     = cnt_q;
    out_bin_d = out_bin_q;
`ifdef BCD2BIN_CHECK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_sr_d = in_bcd;
          bin_sr_d = '0;
          cnt_d    = CW'(BW);
          state_d  = CONV;
`ifdef BCD2BIN_CHECK_EN
          // Bad digits skip conversion and report straight away.
          if (has_bad) begin
            bcd_sr_d  = '0;
            cnt_d     = '0;
            out_bin_d = '0;
            err_d     = 1'b1;
            state_d   = DONE;
          end
`endif
        end
      end
      CONV: begin
        bcd_sr_d = bcd_corr;
        bin_sr_d = bin_shr;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          out_bin_d = bin_shr;
          state_d   = DONE;
`ifdef BCD2BIN_CHECK_EN
          err_d     = 1'b0;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_bin   = out_bin_q;
`ifdef BCD2BIN_CHECK_EN
    out_err   = err_q;
`else
    out_err   = 1'b0;
`endif
  end

endmodule
